packet_queue: RTL and testbench

PACKET_QUEUE -- requirements
Module: packet_queue

---
 rtl/packet_queue.sv | 143 ++++++++++++++
 tb/tb_packet_queue.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/packet_queue.sv
// packet_queue: whole-packet FIFO between a flits buffer and a message consumer.
// Each entry holds a full packet, its valid-flit mask and the mask popcount.
// Define PACKET_QUEUE_STATS_EN to add saturating accepted-packet and stall counters.

`ifndef MAX_PACKET_LENGHT
`define MAX_PACKET_LENGHT 4
`endif
`ifndef FLIT_WIDTH
`define FLIT_WIDTH 8
`endif

module packet_queue #(
  parameter int unsigned N_BITS_QUEUE = 1,
  parameter int unsigned N_BITS_LEN   = 4
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       r_pkt_to_msg_i,
  output logic                                       g_pkt_to_msg_o,
  input  logic [`MAX_PACKET_LENGHT*`FLIT_WIDTH-1:0]  in_link_i,
  input  logic [`MAX_PACKET_LENGHT-1:0]              in_sel_i,
  output logic                                       pkt_valid_o,
  input  logic                                       pkt_ready_i,
  output logic [`MAX_PACKET_LENGHT*`FLIT_WIDTH-1:0]  pkt_link_o,
  output logic [`MAX_PACKET_LENGHT-1:0]              pkt_sel_o,
  output logic [N_BITS_LEN-1:0]                      pkt_len_o,
  output logic                                       full_o,
  output logic                                       empty_o,
  output logic                                       sel_err_o
`ifdef PACKET_QUEUE_STATS_EN
  ,
  output logic [15:0]                                pkt_cnt_o,
  output logic [15:0]                                stall_cnt_o
`endif
);

  localparam int unsigned ML    = `MAX_PACKET_LENGHT;
  localparam int unsigned LW    = `MAX_PACKET_LENGHT * `FLIT_WIDTH;
  localparam int unsigned DEPTH = 2 ** N_BITS_QUEUE;

  localparam logic [N_BITS_QUEUE-1:0] PtrOne   = N_BITS_QUEUE'(1);
  localparam logic [N_BITS_QUEUE:0]   CntOne   = (N_BITS_QUEUE + 1)'(1);
  localparam logic [N_BITS_QUEUE:0]   CntDepth = (N_BITS_QUEUE + 1)'(DEPTH);

  // Packet storage, deliberately not reset
  logic [LW-1:0]         r_link_mem [DEPTH];
  logic [ML-1:0]         r_sel_mem  [DEPTH];
  logic [N_BITS_LEN-1:0] r_len_mem  [DEPTH];

  logic [N_BITS_QUEUE-1:0] r_wr_ptr;
  logic [N_BITS_QUEUE-1:0] r_rd_ptr;
  logic [N_BITS_QUEUE:0]   r_count;
  logic                    r_sel_err;

  logic                  w_full;
  logic                  w_empty;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_sel_ok;
  logic [N_BITS_LEN-1:0] w_in_len;

  function automatic logic [N_BITS_LEN-1:0] popcount(input logic [ML-1:0] sel);
    logic [N_BITS_LEN-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < int'(ML); i++) begin
      cnt = cnt + N_BITS_LEN'(sel[i]);
    end
    return cnt;
  endfunction

  // Occupancy flags come from registered count only, so the grant has no pop-to-push path
  always_comb begin
    w_full   = (r_count == CntDepth);
    w_empty  = (r_count == '0);
    w_push   = r_pkt_to_msg_i & ~w_full & ~rst;
    w_pop    = pkt_ready_i & ~w_empty & ~rst;
    // Mask must be 2**k-1 with k>=1: bit 0 set and no hole above the low run of ones
    w_sel_ok = in_sel_i[0] & ((in_sel_i & (in_sel_i + ML'(1))) == '0);
    w_in_len = popcount(in_sel_i);
  end

  // Capture the granted packet and its precomputed length
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_link_mem[r_wr_ptr] <= in_link_i;
      r_sel_mem[r_wr_ptr]  <= in_sel_i;
      r_len_mem[r_wr_ptr]  <= w_in_len;
    end
  end

  // Pointers, occupancy and sticky mask-error flag
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_sel_err <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PtrOne;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PtrOne;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CntOne;
        2'b01:   r_count <= r_count - CntOne;
        default: r_count <= r_count;
      endcase
      if (w_push && !w_sel_ok) r_sel_err <= 1'b1;
    end
  end

  // Head-of-queue view; mask and length forced to zero when nothing is queued
  always_comb begin
    g_pkt_to_msg_o = w_push;
    pkt_valid_o    = ~w_empty;
    full_o         = w_full;
    empty_o        = w_empty;
    sel_err_o      = r_sel_err;
    pkt_link_o     = r_link_mem[r_rd_ptr];
    pkt_sel_o      = w_empty ? '0 : r_sel_mem[r_rd_ptr];
    pkt_len_o      = w_empty ? '0 : r_len_mem[r_rd_ptr];
  end

`ifdef PACKET_QUEUE_STATS_EN
  logic [15:0] r_pkt_cnt;
  logic [15:0] r_stall_cnt;

  // Saturating counters of accepted packets and refused requests
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pkt_cnt   <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (w_push && (r_pkt_cnt != 16'hFFFF)) r_pkt_cnt <= r_pkt_cnt + 16'd1;
      if (r_pkt_to_msg_i && !w_push && (r_stall_cnt != 16'hFFFF)) begin
        r_stall_cnt <= r_stall_cnt + 16'd1;
      end
    end
  end

  assign pkt_cnt_o   = r_pkt_cnt;
  assign stall_cnt_o = r_stall_cnt;
`endif

endmodule

// File: tb/tb_packet_queue.sv
// Bench for packet_queue: directed vector table for the corner sequences, then
// randomized traffic checked against a queue-based reference model.

`ifndef MAX_PACKET_LENGHT
`define MAX_PACKET_LENGHT 4
`endif
`ifndef FLIT_WIDTH
`define FLIT_WIDTH 8
`endif

module tb_packet_queue;

  localparam int unsigned NQ    = 1;
  localparam int unsigned NL    = 4;
  localparam int unsigned ML    = `MAX_PACKET_LENGHT;
  localparam int unsigned LW    = `MAX_PACKET_LENGHT * `FLIT_WIDTH;
  localparam int unsigned DEPTH = 2 ** NQ;
  localparam int          NVEC  = 21;
  localparam int          NRAND = 800;

  logic          clk = 1'b0;
  logic          rst;
  logic          req;
  logic          grant;
  logic [LW-1:0] link;
  logic [ML-1:0] sel;
  logic          valid;
  logic          rdy;
  logic [LW-1:0] pkt_link;
  logic [ML-1:0] pkt_sel;
  logic [NL-1:0] pkt_len;
  logic          full;
  logic          empty;
  logic          sel_err;
`ifdef PACKET_QUEUE_STATS_EN
  logic [15:0]   pkt_cnt;
  logic [15:0]   stall_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  packet_queue #(
    .N_BITS_QUEUE(NQ),
    .N_BITS_LEN  (NL)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .r_pkt_to_msg_i(req),
    .g_pkt_to_msg_o(grant),
    .in_link_i     (link),
    .in_sel_i      (sel),
    .pkt_valid_o   (valid),
    .pkt_ready_i   (rdy),
    .pkt_link_o    (pkt_link),
    .pkt_sel_o     (pkt_sel),
    .pkt_len_o     (pkt_len),
    .full_o        (full),
    .empty_o       (empty),
    .sel_err_o     (sel_err)
`ifdef PACKET_QUEUE_STATS_EN
    ,
    .pkt_cnt_o     (pkt_cnt),
    .stall_cnt_o   (stall_cnt)
`endif
  );

  typedef struct packed {
    logic          rst;
    logic          req;
    logic          rdy;
    logic [ML-1:0] sel;
    logic          g;
    logic          v;
    logic [NL-1:0] len;
    logic          f;
    logic          e;
    logic          err;
  } vec_t;

  typedef struct {
    logic [LW-1:0] link;
    logic [ML-1:0] sel;
  } pkt_t;

  vec_t tbl [NVEC];
  pkt_t q[$];
  bit   m_err;
  int   m_pkt;
  int   m_stall;

  function automatic vec_t mk(int r, int rq, int rd, int s, int g, int v, int l, int f, int e,
                              int er);
    vec_t t;
    t.rst = r[0];
    t.req = rq[0];
    t.rdy = rd[0];
    t.sel = ML'(s);
    t.g   = g[0];
    t.v   = v[0];
    t.len = NL'(l);
    t.f   = f[0];
    t.e   = e[0];
    t.err = er[0];
    return t;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic bit contiguous(input logic [ML-1:0] s);
    int k;
    k = $countones(s);
    return (k >= 1) && (s == ML'((1 << k) - 1));
  endfunction

  initial begin
    // Columns: rst req rdy sel | grant valid len full empty sel_err (outputs before the edge)
    tbl[0]  = mk(1, 1, 0,  1,  0, 0, 0, 0, 1, 0);  // grant held low during reset
    tbl[1]  = mk(0, 1, 0,  1,  1, 0, 0, 0, 1, 0);  // first request granted same cycle
    tbl[2]  = mk(0, 0, 0,  0,  0, 1, 1, 0, 0, 0);  // visible one cycle later
    tbl[3]  = mk(0, 0, 1,  0,  0, 1, 1, 0, 0, 0);  // pop
    tbl[4]  = mk(0, 0, 1,  0,  0, 0, 0, 0, 1, 0);  // ready while empty is ignored
    tbl[5]  = mk(0, 1, 0,  3,  1, 0, 0, 0, 1, 0);  // three back-to-back requests
    tbl[6]  = mk(0, 1, 0,  7,  1, 1, 2, 0, 0, 0);
    tbl[7]  = mk(0, 1, 0, 15,  0, 1, 2, 1, 0, 0);  // full: stall
    tbl[8]  = mk(0, 1, 1, 15,  0, 1, 2, 1, 0, 0);  // full + pop: still no grant
    tbl[9]  = mk(0, 1, 0, 15,  1, 1, 3, 0, 0, 0);  // grant follows next cycle
    tbl[10] = mk(0, 0, 1,  0,  0, 1, 3, 1, 0, 0);
    tbl[11] = mk(0, 1, 1,  7,  1, 1, 4, 0, 0, 0);  // push+pop on one entry, 5 times
    tbl[12] = mk(0, 1, 1,  1,  1, 1, 3, 0, 0, 0);
    tbl[13] = mk(0, 1, 1,  7,  1, 1, 1, 0, 0, 0);
    tbl[14] = mk(0, 1, 1,  3,  1, 1, 3, 0, 0, 0);
    tbl[15] = mk(0, 1, 1,  7,  1, 1, 2, 0, 0, 0);
    tbl[16] = mk(0, 0, 0,  0,  0, 1, 3, 0, 0, 0);
    tbl[17] = mk(0, 1, 0,  5,  1, 1, 3, 0, 0, 0);  // non-contiguous mask accepted
    tbl[18] = mk(0, 0, 0,  0,  0, 1, 3, 1, 0, 1);  // error flag set, two queued
    tbl[19] = mk(1, 1, 1,  0,  0, 1, 3, 1, 0, 1);  // reset mid-operation
    tbl[20] = mk(0, 0, 0,  0,  0, 0, 0, 0, 1, 0);  // everything discarded

    rst  = 1'b1;
    req  = 1'b0;
    rdy  = 1'b0;
    sel  = '0;
    link = '0;
    repeat (2) @(posedge clk);

    for (int i = 0; i < NVEC; i++) begin
      #1;
      rst  = tbl[i].rst;
      req  = tbl[i].req;
      rdy  = tbl[i].rdy;
      sel  = tbl[i].sel;
      link = LW'({$urandom(), $urandom()});
      @(negedge clk);
      chk($sformatf("vec%0d grant", i), 64'(grant), 64'(tbl[i].g));
      chk($sformatf("vec%0d valid", i), 64'(valid), 64'(tbl[i].v));
      chk($sformatf("vec%0d len", i), 64'(pkt_len), 64'(tbl[i].len));
      chk($sformatf("vec%0d full", i), 64'(full), 64'(tbl[i].f));
      chk($sformatf("vec%0d empty", i), 64'(empty), 64'(tbl[i].e));
      chk($sformatf("vec%0d sel_err", i), 64'(sel_err), 64'(tbl[i].err));
      @(posedge clk);
    end

    // Randomized traffic; model starts empty with cleared flags, first cycle forces reset
    q.delete();
    m_err   = 1'b0;
    m_pkt   = 0;
    m_stall = 0;
    for (int i = 0; i < NRAND; i++) begin
      bit   exp_g;
      int   k;
      pkt_t p;
      #1;
      rst = (i == 0) || ($urandom_range(0, 63) == 0);
      req = ($urandom_range(0, 99) < 70);
      rdy = ($urandom_range(0, 99) < 45);
      if ($urandom_range(0, 1) == 0) begin
        k   = int'($urandom_range(1, ML));
        sel = ML'((1 << k) - 1);
      end else begin
        sel = ML'($urandom());
      end
      link = LW'({$urandom(), $urandom()});
      @(negedge clk);

      exp_g = !rst && req && (q.size() < DEPTH);
      chk("rand grant", 64'(grant), 64'(exp_g));
      chk("rand valid", 64'(valid), 64'(q.size() != 0));
      chk("rand full", 64'(full), 64'(q.size() == DEPTH));
      chk("rand empty", 64'(empty), 64'(q.size() == 0));
      chk("rand sel_err", 64'(sel_err), 64'(m_err));
      if (q.size() != 0) begin
        chk("rand head link", 64'(pkt_link), 64'(q[0].link));
        chk("rand head sel", 64'(pkt_sel), 64'(q[0].sel));
        chk("rand head len", 64'(pkt_len), 64'($countones(q[0].sel)));
      end else begin
        chk("rand empty sel", 64'(pkt_sel), 64'(0));
        chk("rand empty len", 64'(pkt_len), 64'(0));
      end
`ifdef PACKET_QUEUE_STATS_EN
      chk("rand pkt_cnt", 64'(pkt_cnt), 64'(m_pkt));
      chk("rand stall_cnt", 64'(stall_cnt), 64'(m_stall));
`endif

      // Advance the model to the state after the coming edge
      if (rst) begin
        q.delete();
        m_err   = 1'b0;
        m_pkt   = 0;
        m_stall = 0;
      end else begin
        if (rdy && (q.size() != 0)) void'(q.pop_front());
        if (exp_g) begin
          p.link = link;
          p.sel  = sel;
          q.push_back(p);
          if (!contiguous(sel)) m_err = 1'b1;
          if (m_pkt < 65535) m_pkt++;
        end
        if (req && !exp_g && (m_stall < 65535)) m_stall++;
      end
      @(posedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
